// File: rtl/testador_circuito.sv
// Exhaustive tester for a 3-input combinational circuit: walks {a,b,c} through
// 000..111, samples x after a settle delay and compares it against a golden truth table.
module testador_circuito #(
   parameter int unsigned SETTLE   = 1,
   parameter logic [7:0]  EXPECTED = 8'b1000_1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       x,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       fail_valid,
   output logic [2:0] first_fail_idx,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_RELOAD = 4'(SETTLE - 1);

   state_t     state;
   logic [2:0] idx;
   logic [3:0] wait_cnt;

   assign {a, b, c} = idx;
   assign dbg_state = state;

   // x comes straight from a combinational circuit fed by our own registers,
   // so it is already in this clock domain and needs no synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         idx            <= 3'd0;
         wait_cnt       <= 4'd0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= 4'd0;
         fail_valid     <= 1'b0;
         first_fail_idx <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state          <= ST_SETTLE;
                  idx            <= 3'd0;
                  wait_cnt       <= WAIT_RELOAD;
                  busy           <= 1'b1;
                  pass           <= 1'b0;
                  err_count      <= 4'd0;
                  fail_valid     <= 1'b0;
                  first_fail_idx <= 3'd0;
               end
            end
            ST_SETTLE: begin
               if (wait_cnt == 4'd0) state <= ST_SAMPLE;
               else                  wait_cnt <= wait_cnt - 4'd1;
            end
            ST_SAMPLE: begin
               if (x != EXPECTED[idx]) begin
                  // Saturate at 8 so the count can never wrap.
                  if (err_count != 4'd8) err_count <= err_count + 4'd1;
                  if (!fail_valid) begin
                     fail_valid     <= 1'b1;
                     first_fail_idx <= idx;
                  end
               end
               if (idx == 3'd7) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx      <= idx + 3'd1;
                  wait_cnt <= WAIT_RELOAD;
                  state    <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               pass  <= (err_count == 4'd0);
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_testador_circuito.sv
// Directed bench for testador_circuito: correct, stuck-at-0 and inverted CUT models,
// ignored restart, asynchronous mid-run reset, and back-to-back runs with SETTLE=3.
module tb_testador_circuito;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, start3;
   logic       x, x3;
   logic       a, b, c, a3, b3, c3;
   logic       busy, done, pass, busy3, done3, pass3;
   logic [3:0] err_count, err_count3;
   logic       fail_valid, fail_valid3;
   logic [2:0] first_fail_idx, first_fail_idx3;
   logic [1:0] dbg_state, dbg_state3;
   int         mode;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   testador_circuito #(.SETTLE(1), .EXPECTED(8'b1000_1000)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x(x),
      .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_valid(fail_valid),
      .first_fail_idx(first_fail_idx), .dbg_state(dbg_state)
   );

   testador_circuito #(.SETTLE(3), .EXPECTED(8'b1000_1000)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .x(x3),
      .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err_count3), .fail_valid(fail_valid3),
      .first_fail_idx(first_fail_idx3), .dbg_state(dbg_state3)
   );

   // Circuit-under-test models: 0 = b&c (correct), 1 = stuck at 0, 2 = ~(b&c)
   always_comb begin
      case (mode)
         1:       x = 1'b0;
         2:       x = ~(b & c);
         default: x = b & c;
      endcase
   end
   assign x3 = b3 & c3;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Full run with SETTLE=1. k counts the rising edges after the start edge (edge 0);
   // samples are taken on the falling edge following edge k.
   task automatic run(input int mode_i, input bit extra_start, input logic [3:0] e_err,
                      input logic e_fv, input logic [2:0] e_ffi, input logic e_pass);
      mode = mode_i;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 18; k++) begin
         check("done",  done, 8'(k == 16));
         check("busy",  busy, 8'(k < 16));
         if (k < 16) check("abc", {a, b, c}, 8'(k / 2));
         start = (extra_start && k == 5);
         @(negedge clk);
      end
      start = 1'b0;
      check("pass",           pass,           e_pass);
      check("err_count",      err_count,      e_err);
      check("fail_valid",     fail_valid,     e_fv);
      check("first_fail_idx", first_fail_idx, e_ffi);
      @(negedge clk);
      check("pass_hold",      pass,           e_pass);
      check("err_count_hold", err_count,      e_err);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_abc"},  {a, b, c},      8'd0);
      check({tag, "_busy"}, busy,           8'd0);
      check({tag, "_done"}, done,           8'd0);
      check({tag, "_pass"}, pass,           8'd0);
      check({tag, "_err"},  err_count,      8'd0);
      check({tag, "_fv"},   fail_valid,     8'd0);
      check({tag, "_ffi"},  first_fail_idx, 8'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      start3 = 1'b0;
      mode   = 0;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      check("reset3_busy", busy3, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);   // correct circuit
      run(1, 1'b0, 4'd2, 1'b1, 3'd3, 1'b0);   // stuck at 0
      run(2, 1'b0, 4'd8, 1'b1, 3'd0, 1'b0);   // inverted
      run(0, 1'b1, 4'd0, 1'b0, 3'd0, 1'b1);   // restart during run is ignored

      // Stuck-at-0 run aborted by reset while idx=4
      mode = 1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_rst_abc", {a, b, c},      8'd4);
      check("pre_rst_err", err_count,      8'd1);
      check("pre_rst_ffi", first_fail_idx, 8'd3);
      #2 rst_n = 1'b0;
      #1 check_reset_values("async_rst");
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("rst_no_done", done, 8'd0);
         if (k == 2) rst_n = 1'b1;
      end
      check("post_rst_busy", busy, 8'd0);
      run(0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);

      // SETTLE=3 with start held high: runs back to back, one idle cycle between
      @(negedge clk); start3 = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 71; k++) begin
         check("done3", done3, 8'(k == 32 || k == 66));
         check("busy3", busy3, 8'(k < 32 || (k >= 34 && k < 66)));
         if (k < 32)                check("abc3", {a3, b3, c3}, 8'(k / 4));
         else if (k >= 34 && k < 66) check("abc3_run2", {a3, b3, c3}, 8'((k - 34) / 4));
         if (k == 40) start3 = 1'b0;
         @(negedge clk);
      end
      check("pass3",       pass3,       8'd1);
      check("err_count3",  err_count3,  8'd0);
      check("fail_valid3", fail_valid3, 8'd0);
      check("busy3_end",   busy3,       8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/testador_circuito.md
TESTADOR_CIRCUITO -- requirements
Module: testador_circuito

Interface
REQ-001 Parameter SETTLE, default 1: number of clock cycles each test vector is held before x is sampled; legal range 1..15.
REQ-002 Parameter EXPECTED, default 8'b1000_1000: golden truth table; bit i is the required x for vector i, where i = {a,b,c} and a is the MSB.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 start  input  1  request to run the full exhaustive test.
REQ-006 x  input  1  output of the circuit under test.
REQ-007 a, b, c  output  1 each  stimulus driven to the circuit under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  one-cycle pulse marking the end of a run.
REQ-010 pass  output  1  result of the last completed run: 1 means no mismatch.
REQ-011 err_count  output  4  number of mismatching vectors in the current or last run (0..8).
REQ-012 fail_valid  output  1  high once at least one mismatch has been recorded in the current or last run.
REQ-013 first_fail_idx  output  3  index {a,b,c} of the first mismatching vector; valid only while fail_valid=1.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE: when start=1 at a rising edge, the block SHALL go to SETTLE, set idx=0, and clear err_count, fail_valid, first_fail_idx and pass; start in any other state SHALL be ignored.
REQ-016 {a,b,c} SHALL equal the registered idx in every state; busy SHALL be 1 in SETTLE and SAMPLE and 0 otherwise.
REQ-017 SETTLE: a wait counter SHALL hold the block in SETTLE for exactly SETTLE cycles, then move to SAMPLE.
REQ-018 SAMPLE (one cycle): if x != EXPECTED[idx], err_count SHALL increment by 1. If fail_valid was 0, the block SHALL also set fail_valid=1 and first_fail_idx=idx.
REQ-019 SAMPLE exit: if idx=7, go to DONE with idx unchanged; otherwise increment idx and return to SETTLE with the wait counter reloaded.
REQ-020 err_count SHALL never wrap: the maximum of 8 fits in 4 bits, and no increment occurs beyond 8 vectors.
REQ-021 Each vector SHALL occupy SETTLE+1 cycles. With the start edge as cycle 0, done SHALL be high in cycle 8*(SETTLE+1)+1 and only in that cycle.
REQ-022 DONE (one cycle): done=1; pass SHALL be set to 1 when err_count=0 and to 0 otherwise; next state IDLE.
REQ-023 pass, err_count, fail_valid and first_fail_idx SHALL hold their values in IDLE until the next accepted start.
REQ-024 A start held high continuously SHALL begin a new run in the cycle after DONE→IDLE, i.e. one idle cycle between runs.
REQ-025 x SHALL be used directly, without a synchronizer, because the circuit under test is combinational and driven from the same clock domain.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for clk, set: state=IDLE, idx=0, wait counter=0, a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_idx=0.
REQ-027 Reset asserted mid-run SHALL abort the run with no done pulse. After rst_n rises, the first start SHALL begin a clean run from vector 0.

Verification
REQ-028 Correct circuit x=b&c, SETTLE=1, one-cycle start pulse -> done in cycle 17 only; pass=1, err_count=0, fail_valid=0; {a,b,c} steps 000..111, each value held 2 cycles.
REQ-029 x stuck at 0 -> err_count=2, fail_valid=1, first_fail_idx=3'b011, pass=0.
REQ-030 x=~(b&c) -> err_count=8, first_fail_idx=0, pass=0.
REQ-031 rst_n pulsed low while idx=4 -> all outputs at reset values with no clk edge; no done pulse; a new start then gives the result of REQ-028.
REQ-032 start pulsed again during a run -> ignored; done still appears in cycle 17 of the original run.
REQ-033 SETTLE=3, start held high -> each vector held 4 cycles; done in cycle 33; second run's first SETTLE cycle is cycle 35.
